// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: iterative AES-128 key schedule, one shared g-function, 11-slot round-key store.
// Optional KEY_SCHED_ZEROIZE_EN adds a zeroize input that clears all key material.
module key_sched_ctrl #(
  parameter bit RD_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic         zeroize,
`endif
  output logic [127:0] rk_out
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [127:0]  work_q, work_d;
  logic [127:0]  slot_q [11];
  logic [127:0]  slot_d [11];
  logic [127:0]  nxt, rk_d;
  logic [31:0]   t, n0, n1, n2, n3;
  logic          accept, clr;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 by square-and-multiply, then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

`ifdef KEY_SCHED_ZEROIZE_EN
  assign clr = zeroize;
`else
  assign clr = 1'b0;
`endif

  assign key_ready  = state_q != EXPAND;
  assign busy       = state_q == EXPAND;
  assign keys_valid = state_q == DONE;
  assign accept     = key_valid && key_ready;

  assign t   = {sbox(work_q[23:16]), sbox(work_q[15:8]), sbox(work_q[7:0]), sbox(work_q[31:24])}
             ^ {rcon_q, 24'h0};
  assign n0  = work_q[127:96] ^ t;
  assign n1  = work_q[95:64] ^ n0;
  assign n2  = work_q[63:32] ^ n1;
  assign n3  = work_q[31:0] ^ n2;
  assign nxt = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    work_d  = work_q;
    slot_d  = slot_q;
    if (clr) begin
      state_d = IDLE;
      work_d  = '0;
      slot_d  = '{default: '0};
    end else if (accept) begin
      state_d   = EXPAND;
      slot_d[0] = key_in;
      work_d    = key_in;
      rnd_d     = 4'd1;
      rcon_d    = 8'h01;
    end else if (state_q == EXPAND) begin
      work_d  = nxt;
      rnd_d   = rnd_q + 4'd1;
      rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      state_d = rnd_q == 4'd10 ? DONE : EXPAND;
      for (int i = 1; i < 11; i++) slot_d[i] = rnd_q == 4'(i) ? nxt : slot_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      rcon_q  <= '0;
      work_q  <= '0;
      slot_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      work_q  <= work_d;
      slot_q  <= slot_d;
    end
  end

  // Out-of-range indices and any non-DONE state read as zero
  always_comb begin
    rk_d = '0;
    for (int i = 0; i < 11; i++) rk_d = (state_q == DONE && rd_idx == 4'(i)) ? slot_q[i] : rk_d;
  end

  if (RD_REG) begin : g_rd_reg
    logic [127:0] rk_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rk_q <= '0;
      else rk_q <= rk_d;
    end
    assign rk_out = rk_q;
  end else begin : g_rd_comb
    assign rk_out = rk_d;
  end
endmodule
